// File: rtl/div8x4_seq.sv
// Iterative restoring unsigned divider: DW_DVD-bit dividend / DW_DVS-bit divisor, one quotient bit per clock.
// Optional macro DIV_EARLY_TERM_EN: finish in one cycle when the dividend is smaller than the divisor.
module div8x4_seq #(
  parameter int DW_DVD = 8,
  parameter int DW_DVS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW_DVD-1:0] dividend,
  input  logic [DW_DVS-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW_DVD-1:0] quotient,
  output logic [DW_DVS-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CW = (DW_DVD > 1) ? $clog2(DW_DVD) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg;
  logic [DW_DVD-1:0] dvd_reg;
  logic [DW_DVD-1:0] q_reg;
  logic [DW_DVS-1:0] dvs_reg;
  logic [DW_DVS:0]   r_reg;
  logic [CW-1:0]     cnt_reg;
  logic              dbz_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;

  logic [DW_DVS:0]   r_shift;
  logic [DW_DVS:0]   r_trial;
  logic              trial_ok;
  logic              early;
  logic              unused_r_msb;

  // The partial remainder stays below the divisor, so its top bit never feeds the next shift.
  always_comb begin
    r_shift  = {r_reg[DW_DVS-1:0], dvd_reg[DW_DVD-1]};
    r_trial  = r_shift - {1'b0, dvs_reg};
    trial_ok = (r_shift >= {1'b0, dvs_reg});
  end

  assign unused_r_msb = r_reg[DW_DVS];

`ifdef DIV_EARLY_TERM_EN
  assign early = (dividend < DW_DVD'(divisor));
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      q_reg         <= '0;
      r_reg         <= '0;
      cnt_reg       <= '0;
      dbz_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            dvd_reg <= dividend;
            dvs_reg <= divisor;
            r_reg   <= '0;
            dbz_reg <= 1'b0;
            if (divisor == '0) begin
              q_reg         <= '1;
              r_reg         <= {1'b0, dividend[DW_DVS-1:0]};
              dbz_reg       <= 1'b1;
              state_reg     <= DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end else if (early) begin
              q_reg         <= '0;
              r_reg         <= {1'b0, dividend[DW_DVS-1:0]};
              state_reg     <= DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              cnt_reg      <= CW'(DW_DVD - 1);
              state_reg    <= BUSY;
              in_ready_reg <= 1'b0;
            end
          end
        end
        BUSY: begin
          r_reg   <= trial_ok ? r_trial : r_shift;
          q_reg   <= {q_reg[DW_DVD-2:0], trial_ok};
          dvd_reg <= {dvd_reg[DW_DVD-2:0], 1'b0};
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          // Results stay on the outputs after the handoff; only the valid drops.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign quotient    = q_reg;
  assign remainder   = r_reg[DW_DVS-1:0];
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div8x4_seq.sv
// Directed bench for div8x4_seq: reset, normal divides, divide-by-zero, small dividends,
// backpressure, reset abort and a table of hand-computed vectors.
module tb_div8x4_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks;
  int failures;

`ifdef DIV_EARLY_TERM_EN
  localparam int SMALL_LAT = 0;
`else
  localparam int SMALL_LAT = 8;
`endif

  div8x4_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one accept edge, then scramble them to prove they were latched.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  // Latency here is the number of clock edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (quotient !== 8'd0) begin failures++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 4'd0) begin failures++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    rst = 1'b0;
    $display("reset: in_ready=%b out_valid=%b q=%0d r=%0d", in_ready, out_valid, quotient, remainder);
  endtask

  task automatic test_basic();
    int lat;
    start_op(8'd200, 4'd7);
    wait_done(lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (quotient !== 8'd28) begin failures++; $display("FAIL basic_quotient got=%0d exp=28", quotient); end
    checks++; if (remainder !== 4'd4) begin failures++; $display("FAIL basic_remainder got=%0d exp=4", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    $display("200/7: lat=%0d q=%0d r=%0d dbz=%b", lat, quotient, remainder, div_by_zero);
    handoff();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int busy_ready;
    start_op(8'd255, 4'd15);
    lat = 0;
    busy_ready = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready !== 1'b0) busy_ready++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (busy_ready !== 0) begin failures++; $display("FAIL b2b_busy_in_ready got=%0d cycles high exp=0", busy_ready); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_done_in_ready got=%b exp=0", in_ready); end
    checks++; if (quotient !== 8'd17) begin failures++; $display("FAIL b2b_q1 got=%0d exp=17", quotient); end
    checks++; if (remainder !== 4'd0) begin failures++; $display("FAIL b2b_r1 got=%0d exp=0", remainder); end
    $display("255/15: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
    handoff();
    start_op(8'd255, 4'd1);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_busy2_in_ready got=%b exp=0", in_ready); end
    wait_done(lat);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_done2_in_ready got=%b exp=0", in_ready); end
    checks++; if (quotient !== 8'd255) begin failures++; $display("FAIL b2b_q2 got=%0d exp=255", quotient); end
    checks++; if (remainder !== 4'd0) begin failures++; $display("FAIL b2b_r2 got=%0d exp=0", remainder); end
    $display("255/1: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
    handoff();
  endtask

  task automatic test_div_zero();
    start_op(8'd5, 4'd0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dbz_out_valid_next_cycle got=%b exp=1", out_valid); end
    checks++; if (quotient !== 8'hFF) begin failures++; $display("FAIL dbz_quotient got=%h exp=ff", quotient); end
    checks++; if (remainder !== 4'd5) begin failures++; $display("FAIL dbz_remainder got=%0d exp=5", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    $display("5/0: out_valid=%b q=%h r=%0d dbz=%b", out_valid, quotient, remainder, div_by_zero);
    handoff();
  endtask

  task automatic test_small_dividend();
    int lat;
    start_op(8'd3, 4'd9);
    wait_done(lat);
    checks++; if (lat !== SMALL_LAT) begin failures++; $display("FAIL small_latency got=%0d exp=%0d", lat, SMALL_LAT); end
    checks++; if (quotient !== 8'd0) begin failures++; $display("FAIL small_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 4'd3) begin failures++; $display("FAIL small_remainder got=%0d exp=3", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL small_dbz got=%b exp=0", div_by_zero); end
    $display("3/9: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
    handoff();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(8'd100, 4'd3);
    wait_done(lat);
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, out_valid); end
      checks++; if (quotient !== 8'd33 || remainder !== 4'd1) begin
        failures++; $display("FAIL bp_hold_result cyc=%0d got=%0d/%0d exp=33/1", c, quotient, remainder);
      end
      @(posedge clk); #1;
    end
    $display("100/3 held: q=%0d r=%0d", quotient, remainder);
    handoff();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat;
    start_op(8'd200, 4'd7);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    checks++; if (quotient !== 8'd0 || remainder !== 4'd0) begin
      failures++; $display("FAIL abort_result got=%0d/%0d exp=0/0", quotient, remainder);
    end
    start_op(8'd9, 4'd2);
    wait_done(lat);
    checks++; if (quotient !== 8'd4 || remainder !== 4'd1) begin
      failures++; $display("FAIL abort_followup got=%0d/%0d exp=4/1", quotient, remainder);
    end
    $display("9/2 after abort: q=%0d r=%0d", quotient, remainder);
    handoff();
  endtask

  task automatic test_vectors();
    logic [7:0] va [5] = '{8'd13, 8'd128, 8'd1, 8'd0, 8'd250};
    logic [3:0] vb [5] = '{4'd4, 4'd5, 4'd1, 4'd7, 4'd13};
    logic [7:0] vq [5] = '{8'd3, 8'd25, 8'd1, 8'd0, 8'd19};
    logic [3:0] vr [5] = '{4'd1, 4'd3, 4'd0, 4'd0, 4'd3};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i]);
      wait_done(lat);
      checks++; if (quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL vec_%0d %0d/%0d got=%0d/%0d dbz=%b exp=%0d/%0d dbz=0",
                 i, va[i], vb[i], quotient, remainder, div_by_zero, vq[i], vr[i]);
      end
      $display("%0d/%0d: lat=%0d q=%0d r=%0d", va[i], vb[i], lat, quotient, remainder);
      handoff();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_small_dividend();
    test_backpressure();
    test_reset_abort();
    test_vectors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
